// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: counts in-flight writes per architectural
// register and flags RAW hazards for the ID-stage source operands.
module dest_reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int TOT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IssueValid,
  input  logic [4:0]       IssueReg,
  input  logic             RetireValid,
  input  logic [4:0]       RetireReg,
  input  logic [4:0]       SrcA,
  input  logic [4:0]       SrcB,
  output logic             PendingA,
  output logic             PendingB,
  output logic             IssueAccept,
  output logic             Stall,
  output logic [TOT_W-1:0] InFlight,
  output logic             Underflow
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Entry 0 exists only so lookups can index directly; it is held at zero.
  logic [CNT_W-1:0] cnt [32];

  logic [CNT_W-1:0] issueCnt;
  logic [CNT_W-1:0] retireCnt;
  logic             retireSame;
  logic             incValid;
  logic             decValid;
  logic             retireEmpty;

  // A retiring write to the same register frees its own slot in this cycle,
  // and the write-first register file makes it invisible to readers.
  function automatic logic pendingCalc(
    input logic [4:0]       src,
    input logic [CNT_W-1:0] srcCnt,
    input logic             retValid,
    input logic [4:0]       retReg
  );
    logic bypass;
    bypass = retValid && (retReg == src) && (srcCnt == CntOne);
    return (src != 5'd0) && (srcCnt != '0) && !bypass;
  endfunction

  always_comb begin
    issueCnt    = cnt[IssueReg];
    retireCnt   = cnt[RetireReg];
    retireSame  = RetireValid && (RetireReg == IssueReg);
    IssueAccept = IssueValid &&
                  ((IssueReg == 5'd0) || (issueCnt != CntMax) || retireSame);
    incValid    = IssueAccept && (IssueReg != 5'd0);
    decValid    = RetireValid && (RetireReg != 5'd0) && (retireCnt != '0);
    retireEmpty = RetireValid && (RetireReg != 5'd0) && (retireCnt == '0);
    PendingA    = pendingCalc(SrcA, cnt[SrcA], RetireValid, RetireReg);
    PendingB    = pendingCalc(SrcB, cnt[SrcB], RetireValid, RetireReg);
    Stall       = PendingA || PendingB || (IssueValid && !IssueAccept);
  end

  always_ff @(posedge Clk) begin
    cnt[0] <= '0;
    if (Reset) begin
      for (int r = 1; r < 32; r++) cnt[r] <= '0;
      InFlight  <= '0;
      Underflow <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (incValid && (IssueReg == 5'(r)) && !(decValid && (RetireReg == 5'(r))))
          cnt[r] <= cnt[r] + CntOne;
        else if (decValid && (RetireReg == 5'(r)) && !(incValid && (IssueReg == 5'(r))))
          cnt[r] <= cnt[r] - CntOne;
      end
      case ({incValid, decValid})
        2'b10:   InFlight <= InFlight + TOT_W'(1);
        2'b01:   InFlight <= InFlight - TOT_W'(1);
        default: InFlight <= InFlight;
      endcase
      if (retireEmpty) Underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Directed bench for dest_reg_scoreboard: a per-register count model checked
// against every output each cycle, plus hand-computed literal expectations.
module tb_dest_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int TOT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             IssueValid;
  logic [4:0]       IssueReg;
  logic             RetireValid;
  logic [4:0]       RetireReg;
  logic [4:0]       SrcA;
  logic [4:0]       SrcB;
  logic             PendingA;
  logic             PendingB;
  logic             IssueAccept;
  logic             Stall;
  logic [TOT_W-1:0] InFlight;
  logic             Underflow;

  dest_reg_scoreboard #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .IssueValid(IssueValid), .IssueReg(IssueReg),
    .RetireValid(RetireValid), .RetireReg(RetireReg),
    .SrcA(SrcA), .SrcB(SrcB),
    .PendingA(PendingA), .PendingB(PendingB),
    .IssueAccept(IssueAccept), .Stall(Stall),
    .InFlight(InFlight), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Model state: outstanding writes per register, total, sticky error flag.
  int mCnt [32];
  int mTotal = 0;
  bit mUnder = 1'b0;

  initial for (int i = 0; i < 32; i++) mCnt[i] = 0;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mAccept();
    return IssueValid && (IssueReg == 0 || mCnt[IssueReg] < MAXC ||
                          (RetireValid && RetireReg == IssueReg));
  endfunction

  function automatic bit mPending(input logic [4:0] s);
    return s != 0 && mCnt[s] != 0 &&
           !(RetireValid && RetireReg == s && mCnt[s] == 1);
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) mCnt[i] = 0;
      mTotal = 0;
      mUnder = 1'b0;
    end else begin
      bit inc, dec, empty;
      inc   = mAccept() && IssueReg != 0;
      dec   = RetireValid && RetireReg != 0 && mCnt[RetireReg] > 0;
      empty = RetireValid && RetireReg != 0 && mCnt[RetireReg] == 0;
      if (dec) begin mCnt[RetireReg] = mCnt[RetireReg] - 1; mTotal = mTotal - 1; end
      if (inc) begin mCnt[IssueReg] = mCnt[IssueReg] + 1; mTotal = mTotal + 1; end
      if (empty) mUnder = 1'b1;
    end
  end

  always @(negedge Clk) begin
    if (checkEn) begin
      bit pa, pb, acc;
      pa  = mPending(SrcA);
      pb  = mPending(SrcB);
      acc = mAccept();
      cmp("PendingA", int'(PendingA), int'(pa));
      cmp("PendingB", int'(PendingB), int'(pb));
      cmp("IssueAccept", int'(IssueAccept), int'(acc));
      cmp("Stall", int'(Stall), int'(pa || pb || (IssueValid && !acc)));
      cmp("InFlight", int'(InFlight), mTotal);
      cmp("Underflow", int'(Underflow), int'(mUnder));
    end
  end

  task automatic drive(input logic rst, input logic iv, input logic [4:0] ir,
                       input logic rv, input logic [4:0] rr,
                       input logic [4:0] sa, input logic [4:0] sb);
    Reset = rst; IssueValid = iv; IssueReg = ir;
    RetireValid = rv; RetireReg = rr; SrcA = sa; SrcB = sb;
    #2;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checkEn = 1'b1;

    // Idle after reset
    drive(0, 0, 0, 0, 0, 5, 0);
    cmp("rst_PendingA", int'(PendingA), 0);
    cmp("rst_PendingB", int'(PendingB), 0);
    cmp("rst_Stall", int'(Stall), 0);
    cmp("rst_InFlight", int'(InFlight), 0);
    cmp("rst_Underflow", int'(Underflow), 0);
    tick();

    // Issue reg 8, read it back, retire with bypass
    drive(0, 1, 8, 0, 0, 8, 0);
    cmp("iss8_PendingA_c1", int'(PendingA), 0);
    cmp("iss8_Accept", int'(IssueAccept), 1);
    tick();
    drive(0, 0, 0, 0, 0, 8, 0);
    cmp("iss8_PendingA_c2", int'(PendingA), 1);
    cmp("iss8_Stall_c2", int'(Stall), 1);
    cmp("iss8_InFlight_c2", int'(InFlight), 1);
    tick();
    drive(0, 0, 0, 0, 0, 8, 0);
    tick();
    drive(0, 0, 0, 1, 8, 8, 0);
    cmp("ret8_bypass", int'(PendingA), 0);
    cmp("ret8_Stall", int'(Stall), 0);
    tick();
    drive(0, 0, 0, 0, 0, 8, 0);
    cmp("ret8_InFlight", int'(InFlight), 0);
    tick();

    // Fill reg 9 to max, then overflow attempts
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 9, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 9, 0);
    cmp("fill9_InFlight", int'(InFlight), 3);
    drive(0, 1, 9, 0, 0, 0, 0);
    cmp("full9_Accept", int'(IssueAccept), 0);
    cmp("full9_Stall", int'(Stall), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    cmp("full9_InFlight", int'(InFlight), 3);
    drive(0, 1, 9, 1, 9, 0, 9);
    cmp("full9_ret_Accept", int'(IssueAccept), 1);
    cmp("full9_ret_PendingB", int'(PendingB), 1);
    tick();
    drive(0, 0, 0, 0, 0, 9, 0);
    cmp("swap9_InFlight", int'(InFlight), 3);
    cmp("swap9_PendingA", int'(PendingA), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 9, 9, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 9, 0);
    cmp("drain9_InFlight", int'(InFlight), 0);
    cmp("drain9_PendingA", int'(PendingA), 0);
    tick();

    // Register 0 is never tracked
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 0, 0, 0);
      cmp("r0_Accept", int'(IssueAccept), 1);
      cmp("r0_PendingA", int'(PendingA), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    cmp("r0_InFlight", int'(InFlight), 0);
    cmp("r0_Underflow", int'(Underflow), 0);

    // Same-cycle issue and retire of an empty register
    drive(0, 1, 7, 1, 7, 7, 0);
    cmp("empty7_PendingA", int'(PendingA), 0);
    tick();
    drive(0, 0, 0, 0, 0, 7, 0);
    cmp("empty7_InFlight", int'(InFlight), 1);
    cmp("empty7_Underflow", int'(Underflow), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();

    // Retire with nothing pending sets the sticky flag
    drive(0, 0, 0, 1, 12, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    cmp("uf_set", int'(Underflow), 1);
    tick(); tick();
    cmp("uf_sticky", int'(Underflow), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    cmp("uf_cleared", int'(Underflow), 0);
    tick();

    // Reset overrides a simultaneous retire
    drive(0, 1, 3, 0, 0, 0, 0);
    tick();
    drive(0, 1, 4, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 3, 4, 3);
    tick();
    drive(0, 0, 0, 0, 0, 4, 3);
    cmp("rstov_InFlight", int'(InFlight), 0);
    cmp("rstov_PendingA", int'(PendingA), 0);
    cmp("rstov_PendingB", int'(PendingB), 0);
    cmp("rstov_Underflow", int'(Underflow), 0);
    tick(); tick();

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
